// File: rtl/icache_fetch_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : icache_fetch_arbiter_pkg                                      |
// | Brief    : Shared types, constants and round-robin helper for the        |
// |            instruction-cache fetch arbiter.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package icache_fetch_arbiter_pkg;

  localparam int FETCH_BUNDLE_W = 64;
  // Upper bound on requesters; tags are sized for it so the type is fixed.
  localparam int MAX_REQ        = 8;
  localparam int MAX_ID_W       = 3;

  // One outstanding cache request: who issued it and whether it was flushed.
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic                kill;
  } fetch_tag_t;

  // First set bit of valid[n-1:0] searching upward from ptr with wrap-around.
  // Returns -1 when no bit is set.
  function automatic int rr_winner(input logic [MAX_REQ-1:0] valid,
                                   input int ptr,
                                   input int n);
    int idx;
    rr_winner = -1;
    // Walk downward so the smallest offset from ptr is the last one written.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (valid[idx]) rr_winner = idx;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_fetch_arbiter_fetch_tag_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_tag_fifo                                                |
// | Brief    : DEPTH-entry circular FIFO of fetch tags with a broadcast      |
// |            kill-by-ID port that marks every matching entry as killed.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_tag_fifo
  import icache_fetch_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fetch_tag_t         push_tag,
  input  logic               pop,
  input  logic [MAX_REQ-1:0] kill_mask,
  output fetch_tag_t         head_tag,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_tag_t       mem_q [DEPTH];
  fetch_tag_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Next-state: apply broadcast kills, then the push (which may overwrite the
  // slot being popped in the same cycle when the FIFO is full).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (kill_mask[mem_q[e].id]) mem_d[e].kill = 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // State registers; reset empties the FIFO and clears all tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_tag = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/icache_fetch_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : icache_fetch_arbiter                                          |
// | Brief    : Round-robin sharing of one instruction-cache port among       |
// |            NUM_REQ fetch front ends, with in-order response routing and  |
// |            discard of responses for flushed requesters.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module icache_fetch_arbiter
  import icache_fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*32-1:0]         req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            flush,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [FETCH_BUNDLE_W-1:0]     resp_data,
  output logic                          mem_req_valid,
  output logic [31:0]                   mem_req_addr,
  input  logic                          mem_req_ready,
  input  logic                          mem_resp_valid,
  input  logic [FETCH_BUNDLE_W-1:0]     mem_resp_data,
  output logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
  output logic                          err_orphan_resp
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [MAX_REQ-1:0] req_valid_ext;
  logic [MAX_REQ-1:0] flush_ext;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               err_orphan_q, err_orphan_d;
  logic [CNT_W-1:0]   occ;
  logic               fifo_empty;
  logic               pop;
  logic               can_issue;
  logic               accept;
  logic [31:0]        win_addr;
  fetch_tag_t         push_tag;
  fetch_tag_t         head_tag;

  // Widen per-requester vectors to the package's fixed tag-index range.
  always_comb begin
    req_valid_ext                = '0;
    flush_ext                    = '0;
    req_valid_ext[NUM_REQ-1:0]   = req_valid;
    flush_ext[NUM_REQ-1:0]       = flush;
  end

  assign fifo_empty = (occ == '0);
  assign pop        = mem_resp_valid && !fifo_empty;
  // Pop-through: a same-cycle response frees a slot for a new request.
  assign can_issue  = (occ < CNT_W'(MAX_OUT)) || pop;

  // Grant selection and request-side outputs; grant ignores req_ready.
  always_comb begin
    winner        = ID_W'(rr_winner(req_valid_ext, int'(rr_ptr_q), NUM_REQ));
    win_addr      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) win_addr = req_addr[32*i +: 32];
    end
    mem_req_valid = (|req_valid) && can_issue;
    mem_req_addr  = win_addr & 32'hFFFF_FFF8;
    req_ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i) && mem_req_valid && mem_req_ready) req_ready[i] = 1'b1;
    end
  end

  assign accept        = mem_req_valid && mem_req_ready;
  assign push_tag.id   = MAX_ID_W'(winner);
  assign push_tag.kill = flush_ext[push_tag.id];

  fetch_tag_fifo #(
    .DEPTH (MAX_OUT),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_tag  (push_tag),
    .pop       (pop),
    .kill_mask (flush_ext),
    .head_tag  (head_tag),
    .count     (occ)
  );

  // Route the popped response to its issuer unless it was or is being flushed.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pop && head_tag.id == MAX_ID_W'(i) && !head_tag.kill && !flush_ext[head_tag.id])
        resp_valid[i] = 1'b1;
    end
  end

  // Next round-robin pointer and sticky orphan-response flag.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    err_orphan_d = err_orphan_q;
    if (accept) rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    if (mem_resp_valid && fifo_empty) err_orphan_d = 1'b1;
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign resp_data       = mem_resp_data;
  assign outstanding     = occ;
  assign err_orphan_resp = err_orphan_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_icache_fetch_arbiter                                       |
// | Brief    : Self-checking bench for icache_fetch_arbiter: reference model |
// |            of the arbiter plus a response scoreboard and monitor.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_icache_fetch_arbiter;

  localparam int N = 4;
  localparam int M = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  flush = '0;
  logic [N-1:0]  resp_valid;
  logic [63:0]   resp_data;
  logic          mem_req_valid;
  logic [31:0]   mem_req_addr;
  logic          mem_req_ready = 1'b0;
  logic          mem_resp_valid = 1'b0;
  logic [63:0]   mem_resp_data = '0;
  logic [1:0]    outstanding;
  logic          err_orphan_resp;

  icache_fetch_arbiter #(.NUM_REQ(N), .MAX_OUT(M)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .flush           (flush),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .outstanding     (outstanding),
    .err_orphan_resp (err_orphan_resp)
  );

  always #5 clk = ~clk;

  typedef struct { int id; bit killed; } ent_t;
  typedef struct { logic [N-1:0] mask; logic [63:0] data; } exp_t;

  ent_t mq[$];      // model of in-flight requests, oldest first
  exp_t exp_q[$];   // scoreboard of responses that must be delivered
  int   m_rr;
  bit   m_err;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] last_ready, last_resp;
  logic [31:0]  last_addr;
  logic         last_mvalid;
  logic [1:0]   last_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, check request side against the model,
  // advance the model and queue any response that must reach a requester.
  task automatic cycle(input logic [N-1:0] rv, input logic [N*32-1:0] addrs,
                       input logic mrr, input logic [N-1:0] fl,
                       input logic rspv, input logic [63:0] rspd);
    int   w;
    bit   can, exp_mv, popping;
    ent_t head;
    exp_t e;
    @(posedge clk); #1;
    chk("err_orphan", {63'd0, err_orphan_resp}, {63'd0, m_err});
    req_valid = rv; req_addr = addrs; mem_req_ready = mrr; flush = fl;
    mem_resp_valid = rspv; mem_resp_data = rspd;
    #1;
    last_ready = req_ready; last_addr = mem_req_addr; last_mvalid = mem_req_valid;
    last_out = outstanding; last_resp = resp_valid;
    chk("outstanding", 64'(outstanding), 64'(mq.size()));
    popping = rspv && (mq.size() > 0);
    can = (mq.size() < M) || popping;
    w = -1;
    for (int k = N - 1; k >= 0; k--) if (rv[(m_rr + k) % N]) w = (m_rr + k) % N;
    exp_mv = (w >= 0) && can;
    chk("mem_req_valid", 64'(mem_req_valid), 64'(exp_mv));
    chk("req_ready", 64'(req_ready), (exp_mv && mrr) ? 64'(1 << w) : 64'd0);
    if (exp_mv) chk("mem_req_addr", 64'(mem_req_addr), 64'(addrs[32*w +: 32] & 32'hFFFF_FFF8));
    if (rspv && mq.size() == 0) m_err = 1'b1;
    if (popping) begin
      head = mq.pop_front();
      if (!head.killed && !fl[head.id]) begin
        e.mask = N'(1 << head.id); e.data = rspd; exp_q.push_back(e);
      end
    end
    for (int j = 0; j < mq.size(); j++) if (fl[mq[j].id]) mq[j].killed = 1'b1;
    if (exp_mv && mrr) begin
      mq.push_back('{id: w, killed: fl[w]});
      m_rr = (w + 1) % N;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b1, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req_valid = '0; flush = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    rst_n = 1'b0;
    mq.delete(); m_rr = 0; m_err = 1'b0;
    #3;
    chk("reset_outstanding", 64'(outstanding), 64'd0);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_err", 64'(err_orphan_resp), 64'd0);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: every delivered response must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid !== '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_valid", 64'(resp_valid), 64'(e.mask));
          chk("resp_data", resp_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [N*32-1:0] a;
    logic [N-1:0] seq [5];
    logic [N-1:0] fl;
    logic [N-1:0] rv;
    m_rr = 0; m_err = 1'b0;
    do_reset();

    // Single requester with unaligned address.
    a = '0; a[63:32] = 32'h0000_104C;
    cycle(4'b0010, a, 1'b1, '0, 1'b0, '0);
    chk("single_addr", 64'(last_addr), 64'h1048);
    chk("single_ready", 64'(last_ready), 64'b0010);
    cycle('0, '0, 1'b1, '0, 1'b0, '0);
    chk("single_out1", 64'(last_out), 64'd1);
    cycle('0, '0, 1'b1, '0, 1'b1, 64'hDEADBEEF_CAFEF00D);
    chk("single_resp", 64'(last_resp), 64'b0010);
    cycle('0, '0, 1'b1, '0, 1'b0, '0);
    chk("single_out0", 64'(last_out), 64'd0);

    // Round-robin with all requesters asserting.
    do_reset();
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      cycle(4'b1111, a, 1'b1, '0, mq.size() > 0, {$urandom, $urandom});
      chk("rr_grant", 64'(last_ready), 64'(seq[i]));
    end
    idle(1); cycle('0, '0, 1'b1, '0, 1'b1, 64'h1111); cycle('0, '0, 1'b1, '0, 1'b1, 64'h2222);
    idle(1);

    // Backpressure and pop-through.
    do_reset();
    cycle(4'b0001, 128'h40, 1'b1, '0, 1'b0, '0);
    cycle(4'b0010, 128'h40_0000_0000, 1'b1, '0, 1'b0, '0);
    cycle(4'b0100, '0, 1'b1, '0, 1'b0, '0);
    chk("bp_mvalid", 64'(last_mvalid), 64'd0);
    chk("bp_ready", 64'(last_ready), 64'd0);
    cycle(4'b0100, '0, 1'b1, '0, 1'b1, 64'hA5A5);
    chk("pop_through_ready", 64'(last_ready), 64'b0100);
    cycle('0, '0, 1'b1, '0, 1'b1, 64'hB6B6);
    cycle('0, '0, 1'b1, '0, 1'b1, 64'hC7C7);
    idle(1);

    // Flush while in flight.
    do_reset();
    cycle(4'b0100, '0, 1'b1, '0, 1'b0, '0);
    cycle('0, '0, 1'b1, 4'b0100, 1'b0, '0);
    cycle('0, '0, 1'b1, '0, 1'b1, 64'h1234);
    chk("flush_resp", 64'(last_resp), 64'd0);
    cycle('0, '0, 1'b1, '0, 1'b0, '0);
    chk("flush_out0", 64'(last_out), 64'd0);

    // Flush on the accept cycle, and flush on the response cycle.
    cycle(4'b0010, '0, 1'b1, 4'b0010, 1'b0, '0);
    cycle('0, '0, 1'b1, '0, 1'b1, 64'h5678);
    chk("flush_accept_resp", 64'(last_resp), 64'd0);
    cycle(4'b0001, '0, 1'b1, '0, 1'b0, '0);
    cycle('0, '0, 1'b1, 4'b0001, 1'b1, 64'h9ABC);
    chk("flush_resp_cycle", 64'(last_resp), 64'd0);
    idle(1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a  = {$urandom, $urandom, $urandom, $urandom};
      rv = N'($urandom_range(0, 15));
      fl = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, 15)) : '0;
      cycle(rv, a, $urandom_range(0, 3) != 0, fl,
            (mq.size() > 0) && ($urandom_range(0, 1) == 1), {$urandom, $urandom});
    end
    while (mq.size() > 0) cycle('0, '0, 1'b1, '0, 1'b1, {$urandom, $urandom});
    idle(1);

    // Reset with requests outstanding, then an orphan response.
    do_reset();
    cycle(4'b0001, '0, 1'b1, '0, 1'b0, '0);
    cycle(4'b0010, '0, 1'b1, '0, 1'b0, '0);
    cycle('0, '0, 1'b1, '0, 1'b0, '0);
    chk("pre_reset_out", 64'(last_out), 64'd2);
    do_reset();
    cycle('0, '0, 1'b1, '0, 1'b1, 64'hFEED);
    chk("orphan_resp", 64'(last_resp), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle('0, '0, 1'b1, '0, 1'b0, '0);
      chk("orphan_sticky", 64'(err_orphan_resp), 64'd1);
    end

    @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_fetch_arbiter.md
Name: icache_fetch_arbiter

Overview:
- Shares one instruction-cache port among NUM_REQ fetch front ends (one per warp/hart slot) in a compute unit.
- Each front end issues 8-byte-aligned bundle fetches with a valid/ready request handshake and receives a 64-bit response pulse.
- The arbiter picks requesters round-robin and tracks up to MAX_OUT in-order outstanding requests in an ID FIFO.
- It routes each response back to its issuer, and discards responses belonging to requesters that were flushed (redirected) while their fetch was in flight.

Parameters:
- NUM_REQ, 4, number of fetch requesters (2..8).
- MAX_OUT, 2, max outstanding cache requests; ID FIFO depth (1..8).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester fetch request.
- req_addr  in  NUM_REQ*32  per-requester address; slice i is [32*i+31:32*i]; bits [2:0] are ignored and forced to 0.
- req_ready  out  NUM_REQ  per-requester accept, combinational, same cycle.
- flush  in  NUM_REQ  per-requester redirect; kills that requester's in-flight fetches.
- resp_valid  out  NUM_REQ  per-requester response pulse.
- resp_data  out  64  response bundle, shared by all requesters; qualified by resp_valid.
- mem_req_valid  out  1  request to instruction cache.
- mem_req_addr  out  32  {addr[31:3],3'b000}.
- mem_req_ready  in  1  cache accepts this cycle.
- mem_resp_valid  in  1  cache response, in request order, one cycle pulse.
- mem_resp_data  in  64  cache response data.
- outstanding  out  $clog2(MAX_OUT+1)  current ID FIFO occupancy.
- err_orphan_resp  out  1  sticky: mem_resp_valid received with an empty FIFO.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, rr pointer=0, err_orphan_resp=0.
  - All resp_valid=0; outputs settle combinationally from the cleared state.
  - Reset mid-operation drops all tracking. A later response with an empty FIFO sets err_orphan_resp and is not forwarded.
- Arbitration, combinational:
  - can_issue = (occupancy<MAX_OUT) || pop_this_cycle. Pop-through is allowed, so a full FIFO with a same-cycle response still accepts a request.
  - Winner = first i with req_valid[i], searching from rr_ptr upward with wrap-around.
  - mem_req_valid = any req_valid && can_issue. mem_req_addr = winner's address.
  - req_ready[winner] = can_issue && mem_req_ready. All other req_ready = 0.
  - The grant never depends on req_ready, so there is no combinational loop.
- Accept (mem_req_valid && mem_req_ready):
  - Push {id=winner, kill=flush[winner]}. A flush in the same cycle as the accept marks the new entry as killed.
  - rr_ptr <= winner+1 mod NUM_REQ.
  - rr_ptr holds when nothing is accepted.
- Flush, registered effect: every FIFO entry whose id has flush[id]=1 gets kill<=1 at the clock edge. Multiple bits may be set at once.
- Response (mem_resp_valid with FIFO non-empty):
  - Pop the head.
  - resp_valid[head.id] = !head.kill && !flush[head.id], combinational, same cycle. A flush arriving in the same cycle as the response also suppresses it.
  - resp_data = mem_resp_data, passed through with no latency.
- Latency:
  - Request path: 0 cycles.
  - Response path: 0 cycles.
  - Back-to-back grants are possible every cycle.
- Simultaneous push and pop: occupancy unchanged. Pointers wrap mod MAX_OUT.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- outstanding: equals occupancy and includes killed entries.

Decomposition:
- Shared package (e.g. cu_fetch_pkg):
  - FETCH_BUNDLE_W=64.
  - typedef fetch_tag_t {logic [ID_W-1:0] id; logic kill;}.
  - Round-robin helper function.
- Sub-module: fetch_tag_fifo, a MAX_OUT-entry circular FIFO with a broadcast kill-by-ID port.

Test Plan:
- Single requester:
  - Stimulus: NUM_REQ=4. req_valid=4'b0010, addr=0x104C. mem_req_ready=1. Response 0xDEADBEEF_CAFEF00D two cycles later.
  - Required: mem_req_addr=0x1048, req_ready=4'b0010, resp_valid=4'b0010 with that data, outstanding 1 then 0.
- Round-robin:
  - Stimulus: all four requesters valid every cycle, mem_req_ready=1, responses returned continuously.
  - Required: grant order 0,1,2,3,0. No requester is granted twice within 4 grants.
- Backpressure:
  - Stimulus: MAX_OUT=2, two requests accepted, no response, a third request pending.
  - Required: mem_req_valid=0 and req_ready=0. When mem_resp_valid is pulsed, the third request is accepted in the same cycle (pop-through).
- Flush in flight:
  - Stimulus: requester 2 issues; flush[2] pulsed one cycle later; response arrives.
  - Required: resp_valid=0 for all requesters, outstanding returns to 0.
- Same-cycle flush:
  - Stimulus: flush[1] asserted in the cycle requester 1 is accepted, then its response arrives.
  - Required: response is suppressed.
  - Stimulus: flush[0] asserted in the same cycle as requester 0's response.
  - Required: resp_valid[0]=0.
- Reset:
  - Stimulus: rst_n pulsed low with 2 requests outstanding, then mem_resp_valid=1.
  - Required: outstanding=0, no resp_valid, err_orphan_resp=1 and it stays 1 until the next reset.
